bsg_dramsim3_channel_arbiter: RTL and testbench
===============================================

Name: bsg_dramsim3_channel_arbiter

Overview:
- Shares one DRAM channel request/response port among num_req_p requesters, with round-robin arbitration.
- Tracks outstanding reads in a small table keyed by channel address, so read data returned in any order reaches the requester that issued the read.
- Sits between client caches/DMA engines and one channel slice of the nonsynth DRAMsim3 memory model.

Parameters:
- num_req_p, 4, number of requesters (≥2).
- channel_addr_width_p, 29, channel byte-address width.
- data_width_p, 512, data word width.
- max_reads_p, 8, outstanding-read table entries.
- data_mask_width_lp, data_width_p>>3, byte mask width (derived).
- lg_num_req_lp, BSG_SAFE_CLOG2(num_req_p) (derived).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- req_v_i  in  num_req_p  request valid per requester
- req_write_not_read_i  in  num_req_p  1=write
- req_addr_i  in  num_req_p×channel_addr_width_p  channel address
- req_data_i  in  num_req_p×data_width_p  write data
- req_mask_i  in  num_req_p×data_mask_width_lp  byte mask
- req_yumi_o  out  num_req_p  request accepted this cycle
- v_o  out  1  downstream request valid
- write_not_read_o  out  1  downstream write flag
- ch_addr_o  out  channel_addr_width_p  downstream address
- data_v_o  out  1  write data valid (=v_o & write_not_read_o)
- data_o  out  data_width_p  write data
- mask_o  out  data_mask_width_lp  write mask
- yumi_i  in  1  downstream accepts request (and data, if write)
- rd_v_i  in  1  downstream read data valid
- rd_data_i  in  data_width_p  read data
- rd_addr_i  in  channel_addr_width_p  address of returning read
- resp_v_o  out  num_req_p  one-hot read response valid
- resp_data_o  out  data_width_p  read data (broadcast)
- resp_addr_o  out  channel_addr_width_p  read address (broadcast)
- err_o  out  1  sticky: returned read matched no table entry

Behaviour:
- Reset (async on reset_n_i low, released synchronously by design convention): FSM=IDLE; rr pointer=0; table all invalid; resp_v_o=0; err_o=0. v_o=0 while in reset.
- Eligibility: requester i is eligible if req_v_i[i] and one of the following holds:
  - it is a write;
  - it is a read, the table is not full (registered count < max_reads_p), and no valid entry has addr==req_addr_i[i].
- Reads to an address already outstanding stall until that entry frees. The same-address check also compares against an entry freed in the same cycle, so a freeing entry still blocks.
- FSM IDLE: grant the first eligible requester at or after the rr pointer, wrapping modulo num_req_p. Drive v_o and mux the granted requester's fields combinationally.
  - yumi_i=1: req_yumi_o[g]=1; rr pointer ← g+1 (wraps); stay IDLE.
  - yumi_i=0: latch g, go to LOCK.
- FSM LOCK: hold grant g regardless of other requesters; v_o = req_v_i[g]; no eligibility re-check.
  - yumi_i=1: req_yumi_o[g]=1; rr ← g+1; go to IDLE.
  - req_v_i[g] drops without yumi_i: illegal. Simulation assertion fires; go to IDLE.
- yumi_i asserted while v_o=0 is ignored (assertion).
- Read allocation: on a read accept, write {addr, g} into the lowest-index free entry. Count increments.
- Read return: on rd_v_i, find the valid entry whose addr==rd_addr_i and free it.
  - Next cycle: resp_v_o[id]=1 (one cycle), resp_data_o=rd_data_i, resp_addr_o=rd_addr_i. Response latency is exactly 1 cycle after rd_v_i.
  - No match: err_o ← 1 (sticky until reset), resp_v_o stays 0.
- Simultaneous allocate and free in one cycle: count unchanged, both updates applied. Full is judged on the registered count, so no issue into an entry freed that same cycle.
- Writes need no tracking.
- Responses have no back-pressure; requesters must always sink resp_v_o.

Optional Feature:
- Macro BSG_DRAMSIM3_ARB_PERF_EN.
- Defined: per-requester 32-bit saturating counters, cleared by reset:
  - grant_count (increments on req_yumi_o[i]);
  - stall_count (increments when req_v_i[i] & ~req_yumi_o[i]).
- Counters are exposed on output ports perf_grant_o and perf_stall_o [num_req_p][32].
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- All 4 requesters issue reads to 0x100, 0x200, 0x300, 0x400 with yumi_i tied 1 → grants in order 0,1,2,3, one per cycle. Return order 0x300, 0x100, 0x400, 0x200 → resp_v_o = 0100, 0001, 1000, 0010, each 1 cycle after its rd_v_i.
- Requester 2 writes to 0x40 with yumi_i held 0 for 3 cycles while requester 3 is valid → v_o held, ch_addr_o=0x40 throughout. On yumi_i=1, req_yumi_o=0100; next grant goes to requester 3.
- max_reads_p=8: issue 8 reads, no returns; 9th read → req_yumi_o stays 0. One return → 9th accepted at earliest 1 cycle after the free.
- Requester 0 reads 0x80 (outstanding); requester 1 reads 0x80 → stalled until 0x80 returns. Meanwhile requester 1's write to 0x80 (presented instead) proceeds.
- rd_v_i with rd_addr_i=0xDEAD, no entry → err_o=1 and stays 1; resp_v_o=0.
- Drive reset_n_i low mid-LOCK with 3 reads outstanding → v_o=0, table empty, FSM=IDLE immediately. After release, first grant goes to requester 0.

Source files
------------

// File: rtl/bsg_dramsim3_channel_arbiter.sv
// bsg_dramsim3_channel_arbiter
//
// Shares one DRAMsim3 channel request/response port among num_req_p
// requesters using round-robin arbitration. Outstanding reads are held in a
// small table keyed by channel address. Read data that returns in any order
// is routed back to the requester that issued the read.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   req_v_i, req_write_not_read_i, req_addr_i, req_data_i, req_mask_i
//                               per-requester request bundle
//   req_yumi_o                  per-requester "request accepted this cycle"
//   v_o, write_not_read_o, ch_addr_o, data_v_o, data_o, mask_o
//                               downstream request to the channel
//   yumi_i                      downstream accepts the presented request
//   rd_v_i, rd_data_i, rd_addr_i
//                               returning read data from the channel
//   resp_v_o, resp_data_o, resp_addr_o
//                               one-hot, one-cycle registered read response
//   err_o                       sticky: a returned read matched no table entry
//
// Optional feature (macro BSG_DRAMSIM3_ARB_PERF_EN):
//   adds per-requester 32-bit saturating grant and stall counters on
//   perf_grant_o / perf_stall_o.
module bsg_dramsim3_channel_arbiter
  #(parameter int num_req_p = 4
   ,parameter int channel_addr_width_p = 29
   ,parameter int data_width_p = 512
   ,parameter int max_reads_p = 8
   ,localparam int data_mask_width_lp = data_width_p >> 3
   ,localparam int lg_num_req_lp = (num_req_p == 1) ? 1 : $clog2(num_req_p)
   )
  (input  logic clk_i
  ,input  logic reset_n_i

  ,input  logic [num_req_p-1:0] req_v_i
  ,input  logic [num_req_p-1:0] req_write_not_read_i
  ,input  logic [num_req_p-1:0][channel_addr_width_p-1:0] req_addr_i
  ,input  logic [num_req_p-1:0][data_width_p-1:0] req_data_i
  ,input  logic [num_req_p-1:0][data_mask_width_lp-1:0] req_mask_i
  ,output logic [num_req_p-1:0] req_yumi_o

  ,output logic v_o
  ,output logic write_not_read_o
  ,output logic [channel_addr_width_p-1:0] ch_addr_o
  ,output logic data_v_o
  ,output logic [data_width_p-1:0] data_o
  ,output logic [data_mask_width_lp-1:0] mask_o
  ,input  logic yumi_i

  ,input  logic rd_v_i
  ,input  logic [data_width_p-1:0] rd_data_i
  ,input  logic [channel_addr_width_p-1:0] rd_addr_i

  ,output logic [num_req_p-1:0] resp_v_o
  ,output logic [data_width_p-1:0] resp_data_o
  ,output logic [channel_addr_width_p-1:0] resp_addr_o
  ,output logic err_o
`ifdef BSG_DRAMSIM3_ARB_PERF_EN
  ,output logic [num_req_p-1:0][31:0] perf_grant_o
  ,output logic [num_req_p-1:0][31:0] perf_stall_o
`endif
  );

  localparam int lg_max_reads_lp = (max_reads_p == 1) ? 1 : $clog2(max_reads_p);
  localparam int cnt_width_lp = $clog2(max_reads_p + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e state_r;
  logic [lg_num_req_lp-1:0] rr_r, lock_g_r, rr_g, grant_g, rr_next;
  logic rr_found, accept, alloc;

  logic [max_reads_p-1:0] tbl_v_r;
  logic [max_reads_p-1:0][channel_addr_width_p-1:0] tbl_addr_r;
  logic [max_reads_p-1:0][lg_num_req_lp-1:0] tbl_id_r;
  logic [cnt_width_lp-1:0] count_r;

  logic full;
  logic [num_req_p-1:0] addr_busy, eligible;
  logic free_found;
  logic [lg_max_reads_lp-1:0] free_idx;
  logic rd_hit;
  logic [lg_max_reads_lp-1:0] rd_idx;
  logic [lg_num_req_lp-1:0] rd_id;

  logic [num_req_p-1:0] resp_v_r;
  logic [data_width_p-1:0] resp_data_r;
  logic [channel_addr_width_p-1:0] resp_addr_r;
  logic err_r;

  // A read is blocked by any registered-valid entry with the same address,
  // including one being freed this cycle. Fullness uses the registered count,
  // so an entry freed this cycle cannot be reused until the next one.
  always_comb begin
    full = (count_r >= cnt_width_lp'(max_reads_p));
    addr_busy = '0;
    for (int i = 0; i < num_req_p; i++) begin
      for (int e = 0; e < max_reads_p; e++) begin
        if (tbl_v_r[e] && (tbl_addr_r[e] == req_addr_i[i]))
          addr_busy[i] = 1'b1;
      end
    end
    eligible = req_v_i & (req_write_not_read_i | ({num_req_p{~full}} & ~addr_busy));
  end

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    rr_found = 1'b0;
    rr_g = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!rr_found && eligible[(int'(rr_r) + k) % num_req_p]) begin
        rr_found = 1'b1;
        rr_g = lg_num_req_lp'((int'(rr_r) + k) % num_req_p);
      end
    end
  end

  // In LOCK the latched grant is held with no eligibility re-check.
  assign grant_g = (state_r == LOCK) ? lock_g_r : rr_g;
  assign v_o = reset_n_i & ((state_r == LOCK) ? req_v_i[grant_g] : rr_found);
  assign write_not_read_o = req_write_not_read_i[grant_g];
  assign ch_addr_o = req_addr_i[grant_g];
  assign data_o = req_data_i[grant_g];
  assign mask_o = req_mask_i[grant_g];
  assign data_v_o = v_o & write_not_read_o;

  // yumi_i without a valid request is ignored.
  assign accept = v_o & yumi_i;
  assign alloc = accept & ~write_not_read_o;
  assign rr_next = (grant_g == lg_num_req_lp'(num_req_p - 1))
                 ? '0 : grant_g + lg_num_req_lp'(1);

  always_comb begin
    req_yumi_o = '0;
    if (accept)
      req_yumi_o[grant_g] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      rr_r <= '0;
      lock_g_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rr_found) begin
            if (yumi_i)
              rr_r <= rr_next;
            else begin
              lock_g_r <= rr_g;
              state_r <= LOCK;
            end
          end
        end
        LOCK: begin
          if (accept) begin
            rr_r <= rr_next;
            state_r <= IDLE;
          end else if (!req_v_i[lock_g_r]) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Lowest-index free entry for allocation; matching entry for a return.
  always_comb begin
    free_found = 1'b0;
    free_idx = '0;
    for (int e = max_reads_p - 1; e >= 0; e--) begin
      if (!tbl_v_r[e]) begin
        free_found = 1'b1;
        free_idx = lg_max_reads_lp'(e);
      end
    end
    rd_hit = 1'b0;
    rd_idx = '0;
    rd_id = '0;
    for (int e = 0; e < max_reads_p; e++) begin
      if (tbl_v_r[e] && (tbl_addr_r[e] == rd_addr_i)) begin
        rd_hit = 1'b1;
        rd_idx = lg_max_reads_lp'(e);
        rd_id = tbl_id_r[e];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tbl_v_r <= '0;
      count_r <= '0;
    end else begin
      if (rd_v_i && rd_hit)
        tbl_v_r[rd_idx] <= 1'b0;
      if (alloc && free_found)
        tbl_v_r[free_idx] <= 1'b1;
      case ({alloc & free_found, rd_v_i & rd_hit})
        2'b10: count_r <= count_r + cnt_width_lp'(1);
        2'b01: count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload only matters while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (alloc && free_found) begin
      tbl_addr_r[free_idx] <= ch_addr_o;
      tbl_id_r[free_idx] <= grant_g;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_r <= '0;
      err_r <= 1'b0;
    end else begin
      resp_v_r <= '0;
      if (rd_v_i && rd_hit)
        resp_v_r[rd_id] <= 1'b1;
      if (rd_v_i && !rd_hit)
        err_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_v_i) begin
      resp_data_r <= rd_data_i;
      resp_addr_r <= rd_addr_i;
    end
  end

  assign resp_v_o = resp_v_r;
  assign resp_data_o = resp_data_r;
  assign resp_addr_o = resp_addr_r;
  assign err_o = err_r;

`ifdef BSG_DRAMSIM3_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_grant_o <= '0;
      perf_stall_o <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (req_yumi_o[i] && (perf_grant_o[i] != 32'hFFFF_FFFF))
          perf_grant_o[i] <= perf_grant_o[i] + 32'd1;
        if (req_v_i[i] && !req_yumi_o[i] && (perf_stall_o[i] != 32'hFFFF_FFFF))
          perf_stall_o[i] <= perf_stall_o[i] + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A granted requester must hold its request until accepted, and the
  // channel must not accept when nothing is presented.
  yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);
  lock_req_dropped: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == LOCK) |-> req_v_i[lock_g_r]);
`endif

endmodule

// File: tb/tb_bsg_dramsim3_channel_arbiter.sv
// tb_bsg_dramsim3_channel_arbiter
//
// Self-checking bench: directed scenarios plus a randomized phase, all
// compared every cycle against a queue-based behavioural model of the
// arbiter (outstanding reads as a list of {addr, requester}).
module tb_bsg_dramsim3_channel_arbiter;

  localparam int N = 4;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int MAXR = 8;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic [N-1:0] req_v_i, req_write_not_read_i, req_yumi_o;
  logic [N-1:0][AW-1:0] req_addr_i;
  logic [N-1:0][DW-1:0] req_data_i;
  logic [N-1:0][MW-1:0] req_mask_i;
  logic v_o, write_not_read_o, data_v_o, yumi_i;
  logic [AW-1:0] ch_addr_o;
  logic [DW-1:0] data_o;
  logic [MW-1:0] mask_o;
  logic rd_v_i;
  logic [DW-1:0] rd_data_i;
  logic [AW-1:0] rd_addr_i;
  logic [N-1:0] resp_v_o;
  logic [DW-1:0] resp_data_o;
  logic [AW-1:0] resp_addr_o;
  logic err_o;

  bsg_dramsim3_channel_arbiter #(
    .num_req_p(N), .channel_addr_width_p(AW), .data_width_p(DW), .max_reads_p(MAXR)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_write_not_read_i(req_write_not_read_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .req_yumi_o(req_yumi_o),
    .v_o(v_o), .write_not_read_o(write_not_read_o), .ch_addr_o(ch_addr_o),
    .data_v_o(data_v_o), .data_o(data_o), .mask_o(mask_o), .yumi_i(yumi_i),
    .rd_v_i(rd_v_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_addr_o(resp_addr_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    int id;
  } entry_t;

  // behavioural model state
  entry_t outQ[$];
  int mRr;
  bit mLocked;
  int mLockG;
  logic [N-1:0] expRespV;
  logic [DW-1:0] expRespData;
  logic [AW-1:0] expRespAddr;
  logic expErr;
  bit expV;
  int expG;

  // requester-side stimulus state
  bit pend[N];
  bit pWrite[N];
  logic [AW-1:0] pAddr[N];
  logic [DW-1:0] pData[N];
  logic [MW-1:0] pMask[N];
  int yumiMode;
  bit autoReq, autoRet, rdForce;
  logic [AW-1:0] rdForceAddr;

  logic [N-1:0] seenYumi, seenRespV;
  logic seenV, seenErr;
  logic [AW-1:0] seenAddr;

  int total, bad;

  logic [AW-1:0] t1Ret[4];
  logic [N-1:0] t1Resp[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    outQ.delete();
    mRr = 0;
    mLocked = 0;
    mLockG = 0;
    expRespV = '0;
    expRespData = '0;
    expRespAddr = '0;
    expErr = 1'b0;
  endtask

  function automatic bit inTable(input logic [AW-1:0] a);
    foreach (outQ[k]) if (outQ[k].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit anyPend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic setReq(input int i, input bit w, input logic [AW-1:0] a);
    pend[i] = 1'b1;
    pWrite[i] = w;
    pAddr[i] = a;
    pData[i] = {$urandom, $urandom};
    pMask[i] = MW'($urandom);
  endtask

  task automatic driveReqs();
    for (int i = 0; i < N; i++) begin
      req_v_i[i] = pend[i];
      req_write_not_read_i[i] = pWrite[i];
      req_addr_i[i] = pAddr[i];
      req_data_i[i] = pData[i];
      req_mask_i[i] = pMask[i];
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && autoReq && ($urandom_range(0, 1) == 0))
        setReq(i, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 11) * 64));
    end
    driveReqs();
    rd_v_i = 1'b0;
    rd_addr_i = '0;
    rd_data_i = {$urandom, $urandom};
    if (rdForce) begin
      rd_v_i = 1'b1;
      rd_addr_i = rdForceAddr;
      rdForce = 1'b0;
    end else if (autoRet && (outQ.size() > 0) && ($urandom_range(0, 2) == 0)) begin
      int k;
      k = $urandom_range(0, outQ.size() - 1);
      rd_v_i = 1'b1;
      rd_addr_i = outQ[k].addr;
    end
    #1;
    case (yumiMode)
      0: yumi_i = v_o & ($urandom_range(0, 2) != 0);
      1: yumi_i = v_o;
      default: yumi_i = 1'b0;
    endcase
    #1;
  endtask

  task automatic checkOutput();
    logic [N-1:0] expYumi;
    expV = 1'b0;
    expG = 0;
    if (mLocked) begin
      expG = mLockG;
      expV = req_v_i[mLockG];
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mRr + k) % N;
        if (!expV && req_v_i[i] &&
            (req_write_not_read_i[i] || ((outQ.size() < MAXR) && !inTable(req_addr_i[i])))) begin
          expV = 1'b1;
          expG = i;
        end
      end
    end
    expYumi = '0;
    if (expV && yumi_i) expYumi[expG] = 1'b1;

    check("v_o", 64'(v_o), 64'(expV));
    check("req_yumi_o", 64'(req_yumi_o), 64'(expYumi));
    check("data_v_o", 64'(data_v_o), 64'(expV && req_write_not_read_i[expG]));
    if (expV) begin
      check("ch_addr_o", 64'(ch_addr_o), 64'(req_addr_i[expG]));
      check("write_not_read_o", 64'(write_not_read_o), 64'(req_write_not_read_i[expG]));
      if (req_write_not_read_i[expG]) begin
        check("data_o", 64'(data_o), 64'(req_data_i[expG]));
        check("mask_o", 64'(mask_o), 64'(req_mask_i[expG]));
      end
    end
    check("resp_v_o", 64'(resp_v_o), 64'(expRespV));
    if (expRespV != '0) begin
      check("resp_data_o", 64'(resp_data_o), 64'(expRespData));
      check("resp_addr_o", 64'(resp_addr_o), 64'(expRespAddr));
    end
    check("err_o", 64'(err_o), 64'(expErr));

    seenYumi = req_yumi_o;
    seenV = v_o;
    seenAddr = ch_addr_o;
    seenRespV = resp_v_o;
    seenErr = err_o;
  endtask

  task automatic modelUpdate();
    bit acc;
    acc = expV && yumi_i;
    expRespV = '0;
    if (rd_v_i) begin
      int hit;
      hit = -1;
      foreach (outQ[k]) if (outQ[k].addr == rd_addr_i) hit = k;
      if (hit >= 0) begin
        expRespV[outQ[hit].id] = 1'b1;
        expRespData = rd_data_i;
        expRespAddr = rd_addr_i;
        outQ.delete(hit);
      end else begin
        expErr = 1'b1;
      end
    end
    if (acc && !req_write_not_read_i[expG]) begin
      entry_t e;
      e.addr = req_addr_i[expG];
      e.id = expG;
      outQ.push_back(e);
    end
    if (mLocked) begin
      if (acc) begin
        mLocked = 1'b0;
        mRr = (expG + 1) % N;
      end else if (!req_v_i[expG]) begin
        mLocked = 1'b0;
      end
    end else if (expV) begin
      if (acc) mRr = (expG + 1) % N;
      else begin
        mLocked = 1'b1;
        mLockG = expG;
      end
    end
    if (acc) pend[expG] = 1'b0;
  endtask

  task automatic cycle();
    applyStimulus();
    checkOutput();
    modelUpdate();
  endtask

  task automatic drain();
    autoReq = 1'b0;
    yumiMode = 1;
    for (int n = 0; (n < 400) && ((outQ.size() > 0) || anyPend()); n++) begin
      if (outQ.size() > 0) begin
        rdForce = 1'b1;
        rdForceAddr = outQ[0].addr;
      end
      cycle();
    end
    if ((outQ.size() != 0) || anyPend()) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", outQ.size());
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    t1Ret[0] = 'h300; t1Ret[1] = 'h100; t1Ret[2] = 'h400; t1Ret[3] = 'h200;
    t1Resp[0] = 4'b0100; t1Resp[1] = 4'b0001; t1Resp[2] = 4'b1000; t1Resp[3] = 4'b0010;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pWrite[i] = 1'b0; pAddr[i] = '0; pData[i] = '0; pMask[i] = '0;
    end
    yumiMode = 1; autoReq = 1'b0; autoRet = 1'b0; rdForce = 1'b0; rdForceAddr = '0;
    modelReset();
    reset_n_i = 1'b0;
    yumi_i = 1'b0;
    rd_v_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
    // requests present during reset must not reach the channel
    req_v_i = '1;
    req_write_not_read_i = '1;
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_v_o", 64'(v_o), 64'd0);
    check("reset_req_yumi", 64'(req_yumi_o), 64'd0);
    check("reset_resp_v", 64'(resp_v_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    req_v_i = '0;
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;

    $display("[TB] four reads, in-order grants, out-of-order returns");
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'((i + 1) * 'h100));
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t1_grant", 64'(seenYumi), 64'(1) << k);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        rdForce = 1'b1;
        rdForceAddr = t1Ret[k];
      end
      cycle();
      if (k == 0) check("t1_resp_latency", 64'(seenRespV), 64'd0);
      else check("t1_resp", 64'(seenRespV), 64'(t1Resp[k-1]));
    end

    $display("[TB] held write grant under back-pressure");
    setReq(2, 1'b1, 'h40);
    setReq(3, 1'b1, 'h44);
    yumiMode = 2;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t2_hold_v", 64'(seenV), 64'd1);
      check("t2_hold_addr", 64'(seenAddr), 64'h40);
      check("t2_hold_yumi", 64'(seenYumi), 64'd0);
    end
    yumiMode = 1;
    cycle();
    check("t2_accept", 64'(seenYumi), 64'b0100);
    cycle();
    check("t2_next", 64'(seenYumi), 64'b1000);

    $display("[TB] read table full");
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'('h1000 + i * 'h40));
    repeat (4) cycle();
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'('h1100 + i * 'h40));
    repeat (4) cycle();
    check("t3_model_count", 64'(outQ.size()), 64'd8);
    setReq(0, 1'b0, 'h2000);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t3_full_stall", 64'(seenYumi), 64'd0);
    end
    rdForce = 1'b1;
    rdForceAddr = 'h1000;
    cycle();
    check("t3_free_cycle", 64'(seenYumi), 64'd0);
    cycle();
    check("t3_after_free", 64'(seenYumi), 64'b0001);
    drain();

    $display("[TB] same-address read blocking");
    setReq(0, 1'b0, 'h80);
    cycle();
    check("t4_first_read", 64'(seenYumi), 64'b0001);
    setReq(1, 1'b0, 'h80);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_blocked", 64'(seenYumi), 64'd0);
    end
    setReq(1, 1'b1, 'h80);
    cycle();
    check("t4_write_passes", 64'(seenYumi), 64'b0010);
    setReq(1, 1'b0, 'h80);
    cycle();
    check("t4_blocked_again", 64'(seenYumi), 64'd0);
    rdForce = 1'b1;
    rdForceAddr = 'h80;
    cycle();
    check("t4_freeing_blocks", 64'(seenYumi), 64'd0);
    cycle();
    check("t4_unblocked", 64'(seenYumi), 64'b0010);
    check("t4_resp", 64'(seenRespV), 64'b0001);
    drain();

    $display("[TB] randomized traffic");
    autoReq = 1'b1;
    autoRet = 1'b1;
    yumiMode = 0;
    repeat (3000) cycle();
    autoRet = 1'b0;
    drain();

    $display("[TB] unmatched read return");
    rdForce = 1'b1;
    rdForceAddr = 'hDEAD;
    cycle();
    check("t5_err_before", 64'(seenErr), 64'd0);
    cycle();
    check("t5_err_set", 64'(seenErr), 64'd1);
    check("t5_no_resp", 64'(seenRespV), 64'd0);
    repeat (3) cycle();
    check("t5_err_sticky", 64'(seenErr), 64'd1);

    $display("[TB] reset during LOCK with reads outstanding");
    yumiMode = 1;
    setReq(0, 1'b0, 'h500);
    setReq(1, 1'b0, 'h600);
    setReq(2, 1'b0, 'h700);
    repeat (3) cycle();
    check("t6_model_count", 64'(outQ.size()), 64'd3);
    setReq(3, 1'b1, 'h900);
    yumiMode = 2;
    cycle();
    check("t6_lock_v", 64'(seenV), 64'd1);
    check("t6_lock_yumi", 64'(seenYumi), 64'd0);
    @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check("t6_rst_v", 64'(v_o), 64'd0);
    check("t6_rst_yumi", 64'(req_yumi_o), 64'd0);
    check("t6_rst_err", 64'(err_o), 64'd0);
    check("t6_rst_resp", 64'(resp_v_o), 64'd0);
    modelReset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int i = 0; i < N; i++) setReq(i, 1'b0, AW'('h500 + i * 'h100));
    repeat (2) @(negedge clk_i);
    driveReqs();
    #1;
    check("t6_rst_hold_v", 64'(v_o), 64'd0);
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    yumiMode = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_post_grant", 64'(seenYumi), 64'(1) << k);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
